// File: rtl/aes_sbox_scheduler.sv
// Shares four S-box instances between the round datapath (SubBytes, 4 beats)
// and the key schedule (SubWord, 1 beat). Results are registered and
// announced with single-cycle valid pulses.
//
// state | meaning
// IDLE  | no job in flight; ready goes to the arbitration winner
// SUB   | SubBytes in progress, beat counter selects word 0..3
// KEY   | SubWord in progress, result loaded at end of this cycle

// Single combinational AES S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    // Inverse as a^254 (a^0 maps to 0), then the affine transform.
    always_comb begin
        inv = a;
        for (int i = 0; i < 6; i++) inv = gmul(gmul(inv, inv), a);
        inv = gmul(inv, inv);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_sbox_scheduler #(
    parameter int ARB_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_out_valid,
    output logic [31:0]  kw_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, SUB, KEY} state_t;

    state_t        state, state_n;
    logic [1:0]    beat, beat_n;
    logic          rr_key_last;
    logic          key_wins;
    logic [127:0]  st_cap;
    logic [31:0]   kw_cap;
    logic [95:0]   res_q;
    logic [31:0]   sb_in;
    logic [31:0]   sb_out;

    assign busy = (state != IDLE);

    // State register and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 2'd0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    // Arbitration, ready generation and next-state selection.
    always_comb begin
        state_n  = state;
        beat_n   = beat;
        st_ready = 1'b0;
        kw_ready = 1'b0;
        // Mode 1: whoever won the last contest yields; tracker starts key-favoured.
        key_wins = kw_valid && (!st_valid || (ARB_MODE == 0) || !rr_key_last);
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (key_wins) begin
                        kw_ready = 1'b1;
                        state_n  = KEY;
                    end else if (st_valid) begin
                        st_ready = 1'b1;
                        state_n  = SUB;
                        beat_n   = 2'd0;
                    end
                end
            end
            SUB: begin
                beat_n = beat + 2'd1;
                if (beat == 2'd3) state_n = IDLE;
            end
            KEY:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Select the word fed to the shared S-box bank.
    always_comb begin
        sb_in = kw_cap;
        if (state == SUB) begin
            case (beat)
                2'd0:    sb_in = st_cap[31:0];
                2'd1:    sb_in = st_cap[63:32];
                2'd2:    sb_in = st_cap[95:64];
                default: sb_in = st_cap[127:96];
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (sb_in[8*g +: 8]),
            .y (sb_out[8*g +: 8])
        );
    end

    // Capture requests, collect beat results, publish completed jobs.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_cap       <= '0;
            kw_cap       <= '0;
            res_q        <= '0;
            st_out       <= '0;
            kw_out       <= '0;
            st_out_valid <= 1'b0;
            kw_out_valid <= 1'b0;
            rr_key_last  <= 1'b0;
        end else begin
            st_out_valid <= 1'b0;
            kw_out_valid <= 1'b0;
            if (st_ready) st_cap <= st_data;
            if (kw_ready) kw_cap <= kw_data;
            if (state == IDLE && st_valid && kw_valid) rr_key_last <= kw_ready;
            case (state)
                SUB: begin
                    case (beat)
                        2'd0: res_q[31:0]  <= sb_out;
                        2'd1: res_q[63:32] <= sb_out;
                        2'd2: res_q[95:64] <= sb_out;
                        default: begin
                            // Full result appears at once; partial words stay internal.
                            st_out       <= {sb_out, res_q};
                            st_out_valid <= 1'b1;
                        end
                    endcase
                end
                KEY: begin
                    kw_out       <= sb_out;
                    kw_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Bench for aes_sbox_scheduler: fixed-priority instance for most scenarios,
// a round-robin instance for the alternating-grant scenario.
module tb_aes_sbox_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic         st_valid, kw_valid;
    logic [127:0] st_data;
    logic [31:0]  kw_data;
    logic         st_ready, kw_ready, st_out_valid, kw_out_valid, busy;
    logic [127:0] st_out;
    logic [31:0]  kw_out;

    logic         r_st_valid, r_kw_valid;
    logic [127:0] r_st_data;
    logic [31:0]  r_kw_data;
    logic         r_st_ready, r_kw_ready, r_st_out_valid, r_kw_out_valid, r_busy;
    logic [127:0] r_st_out;
    logic [31:0]  r_kw_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbox_ref [256];

    always #5 clk = ~clk;

    aes_sbox_scheduler #(.ARB_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .st_out_valid(st_out_valid), .st_out(st_out),
        .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data),
        .kw_out_valid(kw_out_valid), .kw_out(kw_out), .busy(busy)
    );

    aes_sbox_scheduler #(.ARB_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .st_valid(r_st_valid), .st_ready(r_st_ready), .st_data(r_st_data),
        .st_out_valid(r_st_out_valid), .st_out(r_st_out),
        .kw_valid(r_kw_valid), .kw_ready(r_kw_ready), .kw_data(r_kw_data),
        .kw_out_valid(r_kw_out_valid), .kw_out(r_kw_out), .busy(r_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Reference S-box table from the generator-3 walk of GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_ref[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_ref[0] = 8'h63;
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_ref[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_job(input logic [127:0] d, input logic [127:0] exp, input string tag);
        int w;
        st_data  = d;
        st_valid = 1'b1;
        #1;
        w = 0;
        while (st_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_accept"}, 128'(w < 40), 128'd1);
        chk({tag, "_busy_T"}, 128'(busy), 128'd0);
        step();
        st_valid = 1'b0;
        st_data  = rand128();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("%s_busy_T%0d", tag, k), 128'(busy), 128'd1);
            chk($sformatf("%s_nopulse_T%0d", tag, k), 128'(st_out_valid), 128'd0);
            step();
        end
        chk({tag, "_pulse"}, 128'(st_out_valid), 128'd1);
        chk({tag, "_result"}, st_out, exp);
        chk({tag, "_idle"}, 128'(busy), 128'd0);
        step();
        chk({tag, "_pulse_end"}, 128'(st_out_valid), 128'd0);
        chk({tag, "_hold"}, st_out, exp);
    endtask

    task automatic kw_job(input logic [31:0] d, input logic [31:0] exp, input string tag);
        int w;
        kw_data  = d;
        kw_valid = 1'b1;
        #1;
        w = 0;
        while (kw_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        chk({tag, "_accept"}, 128'(w < 40), 128'd1);
        step();
        kw_valid = 1'b0;
        kw_data  = $urandom;
        chk({tag, "_busy_T1"}, 128'(busy), 128'd1);
        chk({tag, "_nopulse_T1"}, 128'(kw_out_valid), 128'd0);
        step();
        chk({tag, "_pulse"}, 128'(kw_out_valid), 128'd1);
        chk({tag, "_result"}, 128'(kw_out), 128'(exp));
        chk({tag, "_idle"}, 128'(busy), 128'd0);
        step();
        chk({tag, "_pulse_end"}, 128'(kw_out_valid), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_st, prev_st, d128;
        logic [31:0]  exp_kw, prev_kw, d32;
        logic         last_key, key_turn;

        build_sbox();
        rst = 1'b1;
        st_valid = 1'b1; kw_valid = 1'b1; st_data = '0; kw_data = '0;
        r_st_valid = 1'b0; r_kw_valid = 1'b0; r_st_data = '0; r_kw_data = '0;
        step();
        step();
        chk("rst_st_ready", 128'(st_ready), 128'd0);
        chk("rst_kw_ready", 128'(kw_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_st_out", st_out, 128'd0);
        chk("rst_kw_out", 128'(kw_out), 128'd0);
        chk("rst_st_out_valid", 128'(st_out_valid), 128'd0);
        chk("rst_kw_out_valid", 128'(kw_out_valid), 128'd0);
        st_valid = 1'b0; kw_valid = 1'b0; rst = 1'b0;
        step();

        // Known-answer vectors.
        sb_job(128'h00112233445566778899aabbccddeeff,
               128'h638293c31bfc33f5c4eeacea4bc12816, "sb_kat");
        kw_job(32'hcf4f3c09, 32'h8a84eb01, "kw_kat");
        kw_job(32'h00000000, 32'h63636363, "kw_zero");
        kw_job(32'hffffffff, 32'h16161616, "kw_ones");

        // Random jobs against the reference table.
        for (int n = 0; n < 4; n++) begin
            d128 = rand128();
            sb_job(d128, sub_bytes(d128), $sformatf("sb_rand%0d", n));
            d32 = $urandom;
            kw_job(d32, sub_word(d32), $sformatf("kw_rand%0d", n));
        end

        // Fixed priority: key wins ties and can starve the state requester.
        d128 = rand128();
        st_data = d128; st_valid = 1'b1;
        kw_data = $urandom; kw_valid = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("fp_kw_ready%0d", j), 128'(kw_ready), 128'd1);
            chk($sformatf("fp_st_ready%0d", j), 128'(st_ready), 128'd0);
            exp_kw = sub_word(kw_data);
            step();
            kw_data = $urandom;
            chk($sformatf("fp_st_wait%0d", j), 128'(st_ready), 128'd0);
            step();
            chk($sformatf("fp_kw_pulse%0d", j), 128'(kw_out_valid), 128'd1);
            chk($sformatf("fp_kw_out%0d", j), 128'(kw_out), 128'(exp_kw));
        end
        kw_valid = 1'b0;
        #1;
        chk("fp_st_accept", 128'(st_ready), 128'd1);
        step();
        st_valid = 1'b0;
        st_data  = rand128();
        step(); step(); step();
        chk("fp_st_nopulse", 128'(st_out_valid), 128'd0);
        step();
        chk("fp_st_pulse", 128'(st_out_valid), 128'd1);
        chk("fp_st_out", st_out, sub_bytes(d128));
        step();

        // Key request arriving during SUB beat 2 waits for IDLE.
        d128 = rand128();
        exp_st = sub_bytes(d128);
        st_data = d128; st_valid = 1'b1;
        #1;
        chk("mid_st_accept", 128'(st_ready), 128'd1);
        step();
        st_valid = 1'b0; st_data = rand128();
        step();
        step();
        d32 = $urandom;
        kw_data = d32; kw_valid = 1'b1;
        #1;
        chk("mid_kw_ready_b2", 128'(kw_ready), 128'd0);
        step();
        chk("mid_kw_ready_b3", 128'(kw_ready), 128'd0);
        step();
        chk("mid_st_pulse", 128'(st_out_valid), 128'd1);
        chk("mid_st_out", st_out, exp_st);
        chk("mid_kw_ready_idle", 128'(kw_ready), 128'd1);
        step();
        kw_valid = 1'b0; kw_data = $urandom;
        step();
        chk("mid_kw_pulse", 128'(kw_out_valid), 128'd1);
        chk("mid_kw_out", 128'(kw_out), 128'(sub_word(d32)));
        step();

        // Round robin with both requesters held valid continuously.
        last_key = 1'b0;
        prev_st  = '0;
        prev_kw  = '0;
        r_st_data = rand128(); r_kw_data = $urandom;
        r_st_valid = 1'b1; r_kw_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            key_turn = !last_key;
            last_key = key_turn;
            chk($sformatf("rr_kw_ready%0d", g), 128'(r_kw_ready), 128'(key_turn));
            chk($sformatf("rr_st_ready%0d", g), 128'(r_st_ready), 128'(!key_turn));
            if (key_turn) begin
                exp_kw = sub_word(r_kw_data);
                step();
                r_kw_data = $urandom;
                chk($sformatf("rr_kw_nopulse%0d", g), 128'(r_kw_out_valid), 128'd0);
                step();
                chk($sformatf("rr_kw_pulse%0d", g), 128'(r_kw_out_valid), 128'd1);
                chk($sformatf("rr_kw_out%0d", g), 128'(r_kw_out), 128'(exp_kw));
                chk($sformatf("rr_st_hold%0d", g), r_st_out, prev_st);
                prev_kw = exp_kw;
            end else begin
                exp_st = sub_bytes(r_st_data);
                step();
                r_st_data = rand128();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("rr_st_nopulse%0d_%0d", g, k), 128'(r_st_out_valid), 128'd0);
                    chk($sformatf("rr_kw_hold%0d_%0d", g, k), 128'(r_kw_out), 128'(prev_kw));
                    step();
                end
                chk($sformatf("rr_st_nopulse%0d_3", g), 128'(r_st_out_valid), 128'd0);
                step();
                chk($sformatf("rr_st_pulse%0d", g), 128'(r_st_out_valid), 128'd1);
                chk($sformatf("rr_st_out%0d", g), r_st_out, exp_st);
                chk($sformatf("rr_kw_hold%0d", g), 128'(r_kw_out), 128'(prev_kw));
                prev_st = exp_st;
            end
        end
        r_st_valid = 1'b0; r_kw_valid = 1'b0;
        step();

        // Reset during SUB beat 1 aborts the job and clears results.
        st_data = rand128(); st_valid = 1'b1;
        #1;
        chk("rj_accept", 128'(st_ready), 128'd1);
        step();
        st_valid = 1'b0;
        step();
        rst = 1'b1;
        st_valid = 1'b1; kw_valid = 1'b1;
        #1;
        chk("rj_st_ready_rst", 128'(st_ready), 128'd0);
        chk("rj_kw_ready_rst", 128'(kw_ready), 128'd0);
        step();
        chk("rj_busy", 128'(busy), 128'd0);
        chk("rj_st_out", st_out, 128'd0);
        chk("rj_kw_out", 128'(kw_out), 128'd0);
        chk("rj_st_out_valid", 128'(st_out_valid), 128'd0);
        chk("rj_kw_out_valid", 128'(kw_out_valid), 128'd0);
        rst = 1'b0;
        st_valid = 1'b0; kw_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rj_nopulse%0d", k), 128'(st_out_valid), 128'd0);
            step();
        end
        sb_job(128'd0, {16{8'h63}}, "rj_fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
